decoder_load_ctrl: RTL
======================

Name: decoder_load_ctrl

Overview:
- Sequences the decoder datapath on the Zybo Z7 top.
- Assembles a DATA_W-bit command word from single-cycle bit pulses (button-derived, MSB first) and validates its length.
- Presents the word to the decoder over a valid/ready handshake, then holds until the decoder reports completion.
- Reports state, bit count and error flags for LED/debug visibility.

Parameters:
- DATA_W, 48: command word width in bits.
- TIMEOUT_CYC, 1_000_000: maximum clk cycles allowed between bit pulses in LOAD.
- CNT_W, $clog2(DATA_W+1): bit-count width. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock (100 MHz domain).
- ck_rstn  in  1  asynchronous, active-low reset.
- i_bit0  in  1  one-cycle pulse; shift in a 0.
- i_bit1  in  1  one-cycle pulse; shift in a 1.
- i_commit  in  1  one-cycle pulse; submit the assembled word.
- i_abort  in  1  one-cycle pulse; discard and return to IDLE.
- o_word  out  DATA_W  assembled word to the decoder.
- o_valid  out  1  o_word is offered to the decoder.
- i_ready  in  1  decoder accepts o_word.
- i_dec_done  in  1  one-cycle pulse; decoder finished the command.
- o_busy  out  1  high when state is not IDLE and not ERR.
- o_state  out  3  encoded current state.
- o_err  out  2  bit0 = length error (short or overflow); bit1 = inter-bit timeout.
- o_count  out  CNT_W  bits shifted in so far.

Behaviour:
- Reset (async assert, sync release): state IDLE, shift register 0, o_word 0, o_valid 0, o_count 0, o_err 0, timer 0, o_busy 0.
- Shift rule: on a valid bit pulse, sr <= {sr[DATA_W-2:0], bit} and count increments. o_word is driven directly from sr.
- Invalid bit: i_bit0 and i_bit1 asserted in the same cycle is dropped; no shift, no count change. It still restarts the timeout timer.
- State encoding: IDLE=0, LOAD=1, FULL=2, SEND=3, WAIT=4, ERR=5.
- IDLE:
  - Valid bit pulse → LOAD. sr becomes {0..0, bit}, count=1, o_err cleared.
  - i_commit is ignored.
- LOAD:
  - Each valid bit shifts the register and restarts the timer.
  - When count reaches DATA_W → FULL, in the same cycle the last bit is shifted.
  - i_commit with count<DATA_W → ERR with o_err[0]=1.
  - Timer reaching TIMEOUT_CYC-1 → ERR with o_err[1]=1.
  - A bit pulse and i_commit in the same cycle: the bit wins and the commit is dropped.
- FULL:
  - Any bit pulse → ERR with o_err[0]=1 (overflow); sr is not modified.
  - i_commit → SEND. o_valid is high from the next cycle (1-cycle latency).
  - The timer is not running.
- SEND:
  - o_valid=1 with o_word stable until a cycle where o_valid && i_ready.
  - On that edge → WAIT, and o_valid=0 from the next cycle.
  - i_ready asserted before SEND has no effect.
- WAIT:
  - i_dec_done → IDLE, count cleared. o_word keeps its last value.
  - i_dec_done seen in any other state is ignored.
- ERR:
  - o_err holds, o_valid=0.
  - i_abort or i_commit → IDLE with o_err kept.
  - o_err is cleared only by the next LOAD start or by reset.
- i_abort, any state: → IDLE next cycle; sr=0, count=0, o_valid=0, o_err cleared (except when the current state is ERR). i_abort has highest priority over all simultaneous inputs, including abort in SEND with i_ready high, which is not accepted.
- Reset mid-operation: outputs return to reset values asynchronously. A handshake in flight is lost.

Decomposition:
- Package decoder_ctrl_pkg holds:
  - state enum state_e (3-bit, encoding above);
  - error bit index constants ERR_LEN=0, ERR_TMO=1;
  - default DATA_W.
- One sub-module, idle_timer: counter with a restart input, an enable, and a terminal-count pulse at TIMEOUT_CYC-1; parameterised width $clog2(TIMEOUT_CYC).
- The shift register and FSM stay in decoder_load_ctrl.

Test Plan:
- Nominal load: 48 pulses encoding 48'hFF_FF_FF_FF_FF_00, then commit with i_ready=1 → o_valid high exactly 1 cycle, o_word=48'hFFFFFFFFFF00, state WAIT; i_dec_done → IDLE, o_count=0.
- Backpressure: same word, i_ready held 0 for 5 cycles after o_valid rises → o_valid and o_word stable for all 6 cycles, handshake on the 6th, then WAIT.
- Length errors: commit after 10 bits → ERR, o_err=2'b01, o_valid never asserted. A 49th bit after FULL → ERR, o_err=2'b01, o_word unchanged.
- Timeout with TIMEOUT_CYC=16: 3 bits then 16 idle cycles → ERR, o_err=2'b10; one cycle earlier, a bit pulse keeps the state in LOAD.
- Abort and simultaneous events:
  - i_abort during SEND with i_ready=1 in the same cycle → no handshake, IDLE, o_valid=0.
  - i_bit0 & i_bit1 together in LOAD → o_count unchanged.
  - Bit + commit in LOAD → commit dropped.
- Reset mid-LOAD after 20 bits: ck_rstn low for 3 cycles → all outputs 0 immediately; after release a fresh 48-bit load completes normally.

Source files
------------

// File: rtl/decoder_ctrl_pkg.sv
// Shared types and constants for the decoder load controller.
// State encoding is visible on o_state, so it is fixed here.
package decoder_ctrl_pkg;

    localparam int DATA_W_DEF = 48;

    localparam int ERR_LEN = 0;
    localparam int ERR_TMO = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FULL = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/decoder_load_ctrl_idle_timer.sv
// Inter-bit idle timer: counts enabled cycles since the last restart.
// tc pulses when the count sits at TIMEOUT_CYC-1; a restart masks it.
module idle_timer #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int W = $clog2(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tc
);

    logic [W-1:0] cnt;

    assign tc = en && !restart && (cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_load_ctrl.sv
// Assembles a command word from bit pulses, validates its length and
// hands it to the decoder over valid/ready, then waits for completion.
module decoder_load_ctrl
    import decoder_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 1_000_000,
    localparam int CNT_W = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              ck_rstn,
    input  logic              i_bit0,
    input  logic              i_bit1,
    input  logic              i_commit,
    input  logic              i_abort,
    output logic [DATA_W-1:0] o_word,
    output logic              o_valid,
    input  logic              i_ready,
    input  logic              i_dec_done,
    output logic              o_busy,
    output logic [2:0]        o_state,
    output logic [1:0]        o_err,
    output logic [CNT_W-1:0]  o_count
);

    state_e            state;
    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  count;
    logic              valid;
    logic [1:0]        err;

    logic any_bit;
    logic vld_bit;
    logic bit_val;
    logic tmr_en;
    logic tmo;

    // Both bit buttons at once carry no value but still count as activity.
    assign any_bit = i_bit0 | i_bit1;
    assign vld_bit = i_bit0 ^ i_bit1;
    assign bit_val = i_bit1;
    assign tmr_en  = (state == ST_LOAD);

    idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk(clk),
        .rst_n(ck_rstn),
        .en(tmr_en),
        .restart(any_bit),
        .tc(tmo)
    );

    always_ff @(posedge clk or negedge ck_rstn) begin
        if (!ck_rstn) begin
            state <= ST_IDLE;
            sr    <= '0;
            count <= '0;
            valid <= 1'b0;
            err   <= '0;
        end else if (i_abort) begin
            if (state != ST_ERR) err <= '0;
            state <= ST_IDLE;
            sr    <= '0;
            count <= '0;
            valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (vld_bit) begin
                        state <= ST_LOAD;
                        sr    <= {{(DATA_W-1){1'b0}}, bit_val};
                        count <= CNT_W'(1);
                        err   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (vld_bit) begin
                        sr    <= {sr[DATA_W-2:0], bit_val};
                        count <= count + 1'b1;
                        if (count == CNT_W'(DATA_W - 1)) state <= ST_FULL;
                    end else if (i_commit) begin
                        state        <= ST_ERR;
                        err[ERR_LEN] <= 1'b1;
                    end else if (tmo) begin
                        state        <= ST_ERR;
                        err[ERR_TMO] <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (any_bit) begin
                        state        <= ST_ERR;
                        err[ERR_LEN] <= 1'b1;
                    end else if (i_commit) begin
                        state <= ST_SEND;
                        valid <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (valid && i_ready) begin
                        state <= ST_WAIT;
                        valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_dec_done) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end
                end
                ST_ERR: begin
                    if (i_commit) begin
                        state <= ST_IDLE;
                        count <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_word  = sr;
    assign o_valid = valid;
    assign o_state = state;
    assign o_err   = err;
    assign o_count = count;
    assign o_busy  = (state != ST_IDLE) && (state != ST_ERR);

endmodule
